// File: rtl/onchip_block_mover.sv
// onchip_block_mover: Avalon-MM master copying a block of words within on-chip memory (read, latency, write per word).
// Optional constant-fill mode enabled by defining ONCHIP_BLOCK_MOVER_FILL_EN.
module onchip_block_mover #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      length,
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
  input  logic                  fill_mode,
  input  logic [DATA_W-1:0]     fill_pattern,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, LAT = 3'd2, WR = 3'd3, DONE = 3'd4;
  logic [2:0]        state;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              fill_req, fill_q;
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
  assign fill_req = fill_mode;
  always_ff @(posedge clk or posedge reset)
    if (reset) fill_q <= 1'b0;
    else if (state == IDLE && start) fill_q <= fill_mode;
`else
  assign fill_req = 1'b0;
  assign fill_q   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          cnt_q <= length;
          state <= (length == '0) ? DONE : (fill_req ? WR : RD);
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
          if (fill_mode) data_q <= fill_pattern;
`endif
        end
        RD:  state <= LAT;
        LAT: begin
          data_q <= m_readdata;
          state  <= WR;
        end
        WR: begin
          src_q <= src_q + ADDR_W'(1);
          dst_q <= dst_q + ADDR_W'(1);
          cnt_q <= cnt_q - LEN_W'(1);
          state <= (cnt_q == LEN_W'(1)) ? DONE : (fill_q ? WR : RD);
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Bus outputs decode straight from state so an async reset clears them immediately.
  assign m_chipselect = (state == RD) || (state == WR);
  assign m_write      = state == WR;
  assign m_address    = (state == RD) ? src_q : (state == WR) ? dst_q : '0;
  assign m_writedata  = (state == WR) ? data_q : '0;
  assign m_byteenable = {(DATA_W/8){m_chipselect}};
  assign m_clken      = 1'b1;
  assign busy         = (state == RD) || (state == LAT) || (state == WR);
  assign done         = state == DONE;
endmodule

// File: tb/tb_onchip_block_mover.sv
// tb_onchip_block_mover: randomized bench with a memory model and a sequential-copy reference.
module tb_onchip_block_mover;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] src_addr, dst_addr;
  logic [12:0] length;
  logic        busy, done, m_chipselect, m_write, m_clken;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_pattern;
`endif

  onchip_block_mover dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length),
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
    .fill_mode(fill_mode), .fill_pattern(fill_pattern),
`endif
    .busy(busy), .done(done), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
    .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];

  always @(posedge clk) begin
    if (m_chipselect && !m_write) m_readdata <= mem[m_address];
    if (m_chipselect && m_write) mem[m_address] = m_writedata;
  end

  int tests = 0, fails = 0;
  int done_cyc, n_busy, busy_first, busy_last, n_rd, n_wr, bad_be, extra_done;
  logic [11:0] rd_log[$];
  logic [11:0] wr_log[$];

  function automatic int count_mism();
    int m = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  task automatic ref_copy(input logic [11:0] s, input logic [11:0] d, input int l);
    for (int i = 0; i < l; i++) ref_mem[d + 12'(i)] = ref_mem[s + 12'(i)];
  endtask

  task automatic run_xfer(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l,
                          input logic fm, input logic [31:0] pat, input bit noise, input int limit);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
    fill_mode = fm; fill_pattern = pat;
`endif
    @(posedge clk); #1;
    start = 1'b0; src_addr = 12'($urandom); dst_addr = 12'($urandom); length = 13'($urandom);
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
    fill_mode = 1'b0; fill_pattern = $urandom;
`endif
    done_cyc = -1; n_busy = 0; busy_first = -1; busy_last = -1; n_rd = 0; n_wr = 0; bad_be = 0;
    extra_done = 0;
    rd_log.delete(); wr_log.delete();
    for (int c = 1; c <= limit; c++) begin
      start = noise && c >= 2 && c <= 5;
      if (busy) begin
        n_busy++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (m_chipselect) begin
        if (m_byteenable !== 4'hF) bad_be++;
        if (m_write) begin n_wr++; wr_log.push_back(m_address); end
        else begin n_rd++; rd_log.push_back(m_address); end
      end
      if (done) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    if (done) extra_done = 1;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, m_chipselect, m_write, m_clken} !== 5'b00001 || m_address !== 12'h0 ||
        m_writedata !== 32'h0 || m_byteenable !== 4'h0) begin
      fails++;
      $display("FAIL reset_values: got busy=%b done=%b cs=%b wr=%b clken=%b addr=%h wd=%h be=%h required 0 0 0 0 1 000 00000000 0",
               busy, done, m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable);
    end
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) begin mem[12'h010 + i] = 32'hA0 + i; ref_mem[12'h010 + i] = 32'hA0 + i; end
    run_xfer(12'h010, 12'h100, 13'd4, 1'b0, 32'h0, 1'b0, 40);
    ref_copy(12'h010, 12'h100, 4);
    tests++;
    if (done_cyc !== 13) begin fails++; $display("FAIL copy_done_cycle: got %0d required 13", done_cyc); end
    tests++;
    if (n_busy !== 12 || busy_first !== 1 || busy_last !== 12) begin
      fails++; $display("FAIL copy_busy: got n=%0d first=%0d last=%0d required 12 1 12", n_busy, busy_first, busy_last);
    end
    tests++;
    if (extra_done !== 0) begin fails++; $display("FAIL copy_done_width: got %0d extra required 0", extra_done); end
    tests++;
    if (bad_be !== 0) begin fails++; $display("FAIL copy_byteenable: got %0d bad required 0", bad_be); end
    tests++;
    for (int i = 0; i < 4; i++)
      if (mem[12'h100 + i] !== 32'hA0 + i) begin
        fails++; $display("FAIL copy_data[%0d]: got %h required %h", i, mem[12'h100 + i], 32'hA0 + i); break;
      end
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL copy_memory: got %0d mismatching words required 0", count_mism()); end
  endtask

  task automatic test_zero_length();
    run_xfer(12'h055, 12'h066, 13'd0, 1'b0, 32'h0, 1'b0, 10);
    tests++;
    if (done_cyc !== 1) begin fails++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
    tests++;
    if (n_rd + n_wr + n_busy !== 0) begin
      fails++; $display("FAIL zero_no_access: got rd=%0d wr=%0d busy=%0d required 0", n_rd, n_wr, n_busy);
    end
  endtask

  task automatic test_wrap();
    run_xfer(12'hFFE, 12'h020, 13'd4, 1'b0, 32'h0, 1'b0, 40);
    ref_copy(12'hFFE, 12'h020, 4);
    tests++;
    if (rd_log.size() !== 4 || rd_log[0] !== 12'hFFE || rd_log[1] !== 12'hFFF || rd_log[2] !== 12'h000 || rd_log[3] !== 12'h001) begin
      fails++; $display("FAIL wrap_read_order: got %p required FFE FFF 000 001", rd_log);
    end
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL wrap_memory: got %0d mismatching words required 0", count_mism()); end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 8; i++) begin mem[12'h100 + i] = i + 1; ref_mem[12'h100 + i] = i + 1; end
    run_xfer(12'h100, 12'h0FF, 13'd8, 1'b0, 32'h0, 1'b0, 40);
    tests++;
    for (int i = 0; i < 8; i++)
      if (mem[12'h0FF + i] !== i + 1) begin
        fails++; $display("FAIL overlap_data[%0d]: got %0d required %0d", i, mem[12'h0FF + i], i + 1); break;
      end
    ref_copy(12'h100, 12'h0FF, 8);
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL overlap_memory: got %0d mismatching words required 0", count_mism()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 7; t++) begin
      logic [11:0] s, d;
      int l;
      s = 12'($urandom); d = 12'($urandom);
      l = (t == 6) ? 4097 : $urandom_range(1, 24);
      run_xfer(s, d, 13'(l), 1'b0, 32'h0, 1'b0, 3 * l + 8);
      ref_copy(s, d, l);
      tests++;
      if (done_cyc !== 3 * l + 1 || n_rd !== l || n_wr !== l) begin
        fails++; $display("FAIL random%0d_timing: got done=%0d rd=%0d wr=%0d required %0d %0d %0d",
                          t, done_cyc, n_rd, n_wr, 3 * l + 1, l, l);
      end
      tests++;
      if (count_mism() !== 0) begin fails++; $display("FAIL random%0d_memory: got %0d mismatching words required 0", t, count_mism()); end
    end
  endtask

  task automatic test_busy_ignore();
    run_xfer(12'h500, 12'h600, 13'd4, 1'b0, 32'h0, 1'b1, 40);
    ref_copy(12'h500, 12'h600, 4);
    tests++;
    if (done_cyc !== 13 || wr_log.size() !== 4 || wr_log[0] !== 12'h600 || wr_log[3] !== 12'h603) begin
      fails++; $display("FAIL busy_start_ignored: got done=%0d writes=%p required 13 600..603", done_cyc, wr_log);
    end
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL busy_memory: got %0d mismatching words required 0", count_mism()); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    src_addr = 12'h300; dst_addr = 12'h400; length = 13'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({busy, done, m_chipselect, m_write, m_clken} !== 5'b00001 || m_address !== 12'h0 ||
        m_writedata !== 32'h0 || m_byteenable !== 4'h0) begin
      fails++;
      $display("FAIL reset_async: got busy=%b done=%b cs=%b wr=%b clken=%b addr=%h wd=%h be=%h required 0 0 0 0 1 000 00000000 0",
               busy, done, m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable);
    end
    repeat (2) begin @(posedge clk); #1; if (done) seen++; end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d pulses required 0", seen); end
    ref_copy(12'h300, 12'h400, 1);
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL reset_partial: got %0d mismatching words required 0", count_mism()); end
    run_xfer(12'h700, 12'h710, 13'd3, 1'b0, 32'h0, 1'b0, 30);
    ref_copy(12'h700, 12'h710, 3);
    tests++;
    if (done_cyc !== 10 || count_mism() !== 0) begin
      fails++; $display("FAIL reset_restart: got done=%0d mism=%0d required 10 0", done_cyc, count_mism());
    end
  endtask

`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
  task automatic test_fill();
    run_xfer(12'h000, 12'h200, 13'd3, 1'b1, 32'hDEADBEEF, 1'b0, 20);
    for (int i = 0; i < 3; i++) ref_mem[12'h200 + i] = 32'hDEADBEEF;
    tests++;
    if (done_cyc !== 4 || n_rd !== 0 || n_wr !== 3 || busy_first !== 1 || busy_last !== 3) begin
      fails++; $display("FAIL fill_timing: got done=%0d rd=%0d wr=%0d busy=%0d..%0d required 4 0 3 1..3",
                        done_cyc, n_rd, n_wr, busy_first, busy_last);
    end
    tests++;
    if (count_mism() !== 0) begin fails++; $display("FAIL fill_memory: got %0d mismatching words required 0", count_mism()); end
    run_xfer(12'h040, 12'h050, 13'd2, 1'b0, 32'h12345678, 1'b0, 20);
    ref_copy(12'h040, 12'h050, 2);
    tests++;
    if (done_cyc !== 7 || count_mism() !== 0) begin
      fails++; $display("FAIL fill_off_copy: got done=%0d mism=%0d required 7 0", done_cyc, count_mism());
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; m_readdata = '0;
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
    fill_mode = 1'b0; fill_pattern = '0;
`endif
    for (int i = 0; i < 4096; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_copy();
    test_zero_length();
    test_wrap();
    test_overlap();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef ONCHIP_BLOCK_MOVER_FILL_EN
    test_fill();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
